// File: rtl/stdp_pkg.sv
// Shared FSM state encoding and default parameters for the STDP weight-update block.
// Pure declarations: no latency, no flow control.
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_SYN_DEF   = 5;
  localparam int TD_W_DEF      = 8;
  localparam int W_W_DEF       = 8;
  localparam int A_PLUS_DEF    = 16;
  localparam int A_MINUS_DEF   = 12;
  localparam int TAU_SHIFT_DEF = 2;
  localparam int WINDOW_DEF    = 32;
  localparam int W_INIT_DEF    = 128;
  localparam int W_MIN_DEF     = 0;
  localparam int W_MAX_DEF     = 255;

endpackage

// File: rtl/stdp_sat_addsub.sv
// Saturating add/sub of two W_W operands, clipped to [W_MIN, W_MAX], with clip flag.
// Latency 1 cycle (result registered when en=1, held otherwise); no backpressure.
module stdp_sat_addsub #(
  parameter int W_W   = 8,
  parameter int W_MIN = 0,
  parameter int W_MAX = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           sub,
  input  logic [W_W-1:0] a,
  input  logic [W_W-1:0] b,
  output logic [W_W-1:0] res,
  output logic           sat
);

  localparam int XW = W_W + 2;

  logic [W_W-1:0] res_q, res_d;
  logic           sat_q, sat_d;
  logic [XW-1:0]  a_x, b_x, lo_x, hi_x, sum_x;

  always_comb begin
    a_x   = XW'(a);
    b_x   = XW'(b);
    lo_x  = XW'(W_MIN);
    hi_x  = XW'(W_MAX);
    sum_x = a_x + b_x;
    res_d = res_q;
    sat_d = sat_q;
    if (en) begin
      if (sub) begin
        // Compare before subtracting so the extended result never wraps.
        if (a_x < b_x + lo_x) begin
          res_d = W_W'(W_MIN);
          sat_d = 1'b1;
        end else begin
          res_d = W_W'(a_x - b_x);
          sat_d = 1'b0;
        end
      end else if (sum_x > hi_x) begin
        res_d = W_W'(W_MAX);
        sat_d = 1'b1;
      end else begin
        res_d = W_W'(sum_x);
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      sat_q <= 1'b0;
    end else begin
      res_q <= res_d;
      sat_q <= sat_d;
    end
  end

  assign res = res_q;
  assign sat = sat_q;

endmodule

// File: rtl/stdp_weight_update.sv
// STDP weight bank: applies a decaying LTP/LTD step per time-diff transaction, saturating.
// Accept->weight visible 3 cycles (upd_valid pulse then); one transaction per 4 cycles, td_ready only in IDLE.
module stdp_weight_update
  import stdp_pkg::*;
#(
  parameter int NUM_SYN   = NUM_SYN_DEF,
  parameter int TD_W      = TD_W_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int A_PLUS    = A_PLUS_DEF,
  parameter int A_MINUS   = A_MINUS_DEF,
  parameter int TAU_SHIFT = TAU_SHIFT_DEF,
  parameter int WINDOW    = WINDOW_DEF,
  parameter int W_INIT    = W_INIT_DEF,
  parameter int W_MIN     = W_MIN_DEF,
  parameter int W_MAX     = W_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   learn_en,
  input  logic                   td_valid,
  output logic                   td_ready,
  input  logic [2:0]             td_idx,
  input  logic                   td_sign,
  input  logic [TD_W-1:0]        td_mag,
  output logic [NUM_SYN*W_W-1:0] w_flat,
  output logic                   upd_valid,
  output logic [2:0]             upd_idx,
  output logic                   upd_sat,
  output logic                   idx_err
);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            sign_q, sign_d;
  logic            learn_q, learn_d;
  logic            idx_err_q, idx_err_d;
  logic [TD_W-1:0] mag_q, mag_d, sh;
  logic [W_W-1:0]  w_q [NUM_SYN];
  logic [W_W-1:0]  w_d [NUM_SYN];
  logic [W_W-1:0]  w_cur, step, delta, add_res;
  logic            add_sat, idx_ok;

  assign idx_ok = int'(idx_q) < NUM_SYN;

  // Step size from the latched transaction; evaluated while in CALC.
  always_comb begin
    sh    = mag_q >> TAU_SHIFT;
    step  = sign_q ? W_W'(A_PLUS) : W_W'(A_MINUS);
    delta = '0;
    if (mag_q != '0 && int'(mag_q) <= WINDOW && learn_q && idx_ok && int'(sh) < W_W) begin
      delta = step >> sh;
    end
  end

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_SYN; i++) begin
      if (int'(idx_q) == i) w_cur = w_q[i];
    end
  end

  stdp_sat_addsub #(
    .W_W   (W_W),
    .W_MIN (W_MIN),
    .W_MAX (W_MAX)
  ) u_addsub (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_CALC),
    .sub   (~sign_q),
    .a     (w_cur),
    .b     (delta),
    .res   (add_res),
    .sat   (add_sat)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    learn_d   = learn_q;
    idx_err_d = idx_err_q;
    w_d       = w_q;
    case (state_q)
      ST_IDLE: begin
        if (td_valid) begin
          idx_d   = td_idx;
          sign_d  = td_sign;
          mag_d   = td_mag;
          learn_d = learn_en;
          state_d = ST_CALC;
        end
      end
      ST_CALC:  state_d = ST_APPLY;
      ST_APPLY: begin
        if (idx_ok) begin
          for (int i = 0; i < NUM_SYN; i++) begin
            if (int'(idx_q) == i) w_d[i] = add_res;
          end
        end else begin
          idx_err_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      learn_q   <= 1'b0;
      idx_err_q <= 1'b0;
      for (int i = 0; i < NUM_SYN; i++) w_q[i] <= W_W'(W_INIT);
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      learn_q   <= learn_d;
      idx_err_q <= idx_err_d;
      w_q       <= w_d;
    end
  end

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < NUM_SYN; i++) w_flat[i*W_W +: W_W] = w_q[i];
  end

  assign td_ready  = (state_q == ST_IDLE);
  assign upd_valid = (state_q == ST_DONE);
  assign upd_idx   = idx_q;
  assign upd_sat   = (state_q == ST_DONE) & add_sat;
  assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_stdp_weight_update.sv
// Directed bench for stdp_weight_update with hand-computed weights and handshake timing.
module tb_stdp_weight_update;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        learn_en;
  logic        td_valid;
  logic        td_ready;
  logic [2:0]  td_idx;
  logic        td_sign;
  logic [7:0]  td_mag;
  logic [39:0] w_flat;
  logic        upd_valid;
  logic [2:0]  upd_idx;
  logic        upd_sat;
  logic        idx_err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_w [5];

  always #5 clk = ~clk;

  stdp_weight_update dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .learn_en  (learn_en),
    .td_valid  (td_valid),
    .td_ready  (td_ready),
    .td_idx    (td_idx),
    .td_sign   (td_sign),
    .td_mag    (td_mag),
    .w_flat    (w_flat),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_sat   (upd_sat),
    .idx_err   (idx_err)
  );

  function automatic logic [39:0] exp_flat();
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = exp_w[i];
    return r;
  endfunction

  // Drives one transaction, returns cycles from accept to upd_valid (-1 on timeout),
  // leaving the caller at the falling edge inside the DONE cycle.
  task automatic do_txn(input logic [2:0] idx, input logic sign, input logic [7:0] mag,
                        input logic learn, output int lat, output logic sat,
                        output logic [2:0] uidx);
    int n;
    @(negedge clk);
    td_valid = 1'b1; td_idx = idx; td_sign = sign; td_mag = mag; learn_en = learn;
    n = 0;
    while (!td_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    td_valid = 1'b0;
    learn_en = ~learn;
    lat = 1;
    while (!upd_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!upd_valid) lat = -1;
    sat  = upd_sat;
    uidx = upd_idx;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) exp_w[i] = 8'd128;
    checks++;
    if (w_flat !== exp_flat()) begin
      failures++; $display("FAIL reset_w: got %h want %h", w_flat, exp_flat());
    end
    checks++;
    if (td_ready !== 1'b1 || upd_valid !== 1'b0 || idx_err !== 1'b0 || upd_sat !== 1'b0 || upd_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_ctl: got rdy=%b vld=%b err=%b sat=%b idx=%0d want 1 0 0 0 0",
               td_ready, upd_valid, idx_err, upd_sat, upd_idx);
    end
  endtask

  task automatic test_ltp();
    int lat; logic sat; logic [2:0] uidx;
    do_txn(3'd2, 1'b1, 8'd5, 1'b1, lat, sat, uidx);
    exp_w[2] = 8'd136;
    checks++;
    if (lat !== 3 || uidx !== 3'd2 || sat !== 1'b0) begin
      failures++; $display("FAIL ltp_upd: got lat=%0d idx=%0d sat=%b want 3 2 0", lat, uidx, sat);
    end
    checks++;
    if (w_flat !== exp_flat()) begin
      failures++; $display("FAIL ltp_w: got %h want %h", w_flat, exp_flat());
    end
    @(negedge clk);
    checks++;
    if (upd_valid !== 1'b0 || td_ready !== 1'b1) begin
      failures++; $display("FAIL ltp_pulse: got vld=%b rdy=%b want 0 1", upd_valid, td_ready);
    end
  endtask

  task automatic test_ltd();
    int lat; logic sat; logic [2:0] uidx;
    do_txn(3'd0, 1'b0, 8'd1, 1'b1, lat, sat, uidx);
    exp_w[0] = 8'd116;
    checks++;
    if (w_flat !== exp_flat() || sat !== 1'b0 || uidx !== 3'd0) begin
      failures++; $display("FAIL ltd_w: got %h sat=%b want %h sat=0", w_flat, sat, exp_flat());
    end
    do_txn(3'd0, 1'b0, 8'd40, 1'b1, lat, sat, uidx);
    checks++;
    if (w_flat !== exp_flat() || lat !== 3) begin
      failures++; $display("FAIL ltd_window: got %h lat=%0d want %h lat=3", w_flat, lat, exp_flat());
    end
  endtask

  task automatic test_bounds();
    int lat; logic sat; logic [2:0] uidx;
    logic [7:0] mags [4] = '{8'd0, 8'd32, 8'd16, 8'd8};
    logic       sgns [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] wants[4] = '{8'd128, 8'd128, 8'd129, 8'd126};
    for (int k = 0; k < 4; k++) begin
      do_txn(3'd3, sgns[k], mags[k], 1'b1, lat, sat, uidx);
      exp_w[3] = wants[k];
      checks++;
      if (w_flat !== exp_flat()) begin
        failures++; $display("FAIL bounds_mag%0d: got %h want %h", mags[k], w_flat, exp_flat());
      end
    end
    do_txn(3'd3, 1'b1, 8'd1, 1'b0, lat, sat, uidx);
    checks++;
    if (w_flat !== exp_flat() || lat !== 3) begin
      failures++; $display("FAIL learn_off: got %h lat=%0d want %h lat=3", w_flat, lat, exp_flat());
    end
  endtask

  task automatic test_saturation();
    int lat; logic sat; logic [2:0] uidx;
    for (int k = 0; k < 7; k++) do_txn(3'd4, 1'b1, 8'd1, 1'b1, lat, sat, uidx);
    do_txn(3'd4, 1'b1, 8'd5, 1'b1, lat, sat, uidx);
    do_txn(3'd4, 1'b1, 8'd12, 1'b1, lat, sat, uidx);
    exp_w[4] = 8'd250;
    checks++;
    if (w_flat !== exp_flat() || sat !== 1'b0) begin
      failures++; $display("FAIL sat_preload: got %h sat=%b want %h sat=0", w_flat, sat, exp_flat());
    end
    do_txn(3'd4, 1'b1, 8'd1, 1'b1, lat, sat, uidx);
    exp_w[4] = 8'd255;
    checks++;
    if (w_flat !== exp_flat() || sat !== 1'b1) begin
      failures++; $display("FAIL sat_max: got %h sat=%b want %h sat=1", w_flat, sat, exp_flat());
    end
    for (int k = 0; k < 9; k++) do_txn(3'd0, 1'b0, 8'd1, 1'b1, lat, sat, uidx);
    exp_w[0] = 8'd8;
    checks++;
    if (w_flat !== exp_flat() || sat !== 1'b0) begin
      failures++; $display("FAIL sat_pre_min: got %h sat=%b want %h sat=0", w_flat, sat, exp_flat());
    end
    do_txn(3'd0, 1'b0, 8'd1, 1'b1, lat, sat, uidx);
    exp_w[0] = 8'd0;
    checks++;
    if (w_flat !== exp_flat() || sat !== 1'b1) begin
      failures++; $display("FAIL sat_min: got %h sat=%b want %h sat=1", w_flat, sat, exp_flat());
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    logic rdy_seen [8];
    logic rdy_want [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    @(negedge clk);
    td_valid = 1'b1; td_idx = 3'd1; td_sign = 1'b1; td_mag = 8'd8; learn_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rdy_seen[c] = td_ready;
      if (td_valid && td_ready) acc++;
      @(negedge clk);
    end
    td_valid = 1'b0;
    checks++;
    if (acc !== 2) begin
      failures++; $display("FAIL b2b_accepts: got %0d want 2", acc);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (rdy_seen[c] !== rdy_want[c]) begin
        failures++; $display("FAIL b2b_ready%0d: got %b want %b", c, rdy_seen[c], rdy_want[c]);
      end
    end
    exp_w[1] = 8'd136;
    checks++;
    if (w_flat !== exp_flat() || td_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_w: got %h rdy=%b want %h rdy=1", w_flat, td_ready, exp_flat());
    end
  endtask

  task automatic test_errors_reset();
    int lat; logic sat; logic [2:0] uidx;
    do_txn(3'd6, 1'b1, 8'd1, 1'b1, lat, sat, uidx);
    checks++;
    if (w_flat !== exp_flat() || idx_err !== 1'b1 || uidx !== 3'd6 || sat !== 1'b0) begin
      failures++;
      $display("FAIL bad_idx: got w=%h err=%b idx=%0d sat=%b want w=%h err=1 idx=6 sat=0",
               w_flat, idx_err, uidx, sat, exp_flat());
    end
    @(negedge clk);
    td_valid = 1'b1; td_idx = 3'd2; td_sign = 1'b1; td_mag = 8'd1; learn_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    td_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) exp_w[i] = 8'd128;
    checks++;
    if (w_flat !== exp_flat() || idx_err !== 1'b0 || upd_valid !== 1'b0) begin
      failures++; $display("FAIL rst_apply: got w=%h err=%b vld=%b want w=%h 0 0",
                           w_flat, idx_err, upd_valid, exp_flat());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) @(negedge clk);
    checks++;
    if (w_flat !== exp_flat() || td_ready !== 1'b1 || upd_valid !== 1'b0) begin
      failures++; $display("FAIL rst_after: got w=%h rdy=%b vld=%b want w=%h 1 0",
                           w_flat, td_ready, upd_valid, exp_flat());
    end
  endtask

  initial begin
    rst_n = 1'b0; learn_en = 1'b1; td_valid = 1'b0;
    td_idx = 3'd0; td_sign = 1'b0; td_mag = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_ltp();
    test_ltd();
    test_bounds();
    test_saturation();
    test_back_to_back();
    test_errors_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
